uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of `uartController` among `N_REQ` byte producers (e.g. core store path, debug monitor, switch/button logic). It selects one pending requester, issues a one-cycle write of its byte into the controller, and follows the controller's TX-busy status until the byte has left the transmitter. Only then does it consider the next request. It sits between the requesters and `uartController`, replacing the ad-hoc `e_write` driving done at top level.

---
 rtl/uart_tx_arbiter.sv | 102 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing the uartController write port
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   grant,
    input  logic               tx_busy,
    output logic               e_write,
    output logic [31:0]        w_data,
    output logic               arb_busy,
    output logic               err,
    output logic [15:0]        sent_cnt
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   sel_idx;
    logic [TW-1:0]   tmr;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [7:0]      win_byte;

    // Walk offsets from farthest to nearest so the nearest asserted request after ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = IW'((int'(ptr) + off) % N_REQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_byte = data[8*win_idx +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= IW'(N_REQ - 1);
            sel_idx  <= '0;
            tmr      <= '0;
            grant    <= '0;
            e_write  <= 1'b0;
            w_data   <= '0;
            arb_busy <= 1'b0;
            err      <= 1'b0;
            sent_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!tx_busy && win_found) begin
                        sel_idx  <= win_idx;
                        w_data   <= {24'b0, win_byte};
                        e_write  <= 1'b1;
                        grant    <= N_REQ'(1) << win_idx;
                        arb_busy <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    e_write <= 1'b0;
                    grant   <= '0;
                    ptr     <= sel_idx;
                    tmr     <= TW'(ACK_TIMEOUT - 1);
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmr == '0) begin
                        err      <= 1'b1;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                WAIT_DONE: begin
                    // Unbounded on purpose: slow baud rates can keep the shifter busy for a long time.
                    if (!tx_busy) begin
                        sent_cnt <= sent_cnt + 16'd1;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        tx_busy;
    logic        e_write;
    logic [31:0] w_data;
    logic        arb_busy;
    logic        err;
    logic [15:0] sent_cnt;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.N_REQ(4), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant),
        .tx_busy(tx_busy), .e_write(e_write), .w_data(w_data),
        .arb_busy(arb_busy), .err(err), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1; req = '0; tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a write, then plays a short controller busy pulse.
    task automatic do_xfer(input logic [3:0] r, input bit drop, output int g, output logic [31:0] wd);
        g = -1; wd = '0; req = r;
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk);
            if (e_write === 1'b1) begin
                wd = w_data;
                for (int j = 0; j < 4; j++) if (grant[j] === 1'b1) g = j;
            end
        end
        if (drop && g >= 0) req[g] = 1'b0;
        if (g >= 0) begin
            tx_busy = 1'b1;
            repeat (3) @(negedge clk);
            tx_busy = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (grant !== 4'b0)    begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        total++; if (e_write !== 1'b0)  begin bad++; $display("FAIL reset_e_write got=%b exp=0", e_write); end
        total++; if (w_data !== 32'h0)  begin bad++; $display("FAIL reset_w_data got=%h exp=0", w_data); end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL reset_arb_busy got=%b exp=0", arb_busy); end
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (sent_cnt !== 16'd0) begin bad++; $display("FAIL reset_sent_cnt got=%0d exp=0", sent_cnt); end
    endtask

    task automatic test_single();
        apply_reset();
        data = 32'h44332241;
        req = 4'b0001;
        @(negedge clk);
        total++; if (e_write !== 1'b1)        begin bad++; $display("FAIL single_e_write got=%b exp=1", e_write); end
        total++; if (grant !== 4'b0001)       begin bad++; $display("FAIL single_grant got=%b exp=0001", grant); end
        total++; if (w_data !== 32'h00000041) begin bad++; $display("FAIL single_w_data got=%h exp=00000041", w_data); end
        req = 4'b0000;
        @(negedge clk);
        total++; if (e_write !== 1'b0)        begin bad++; $display("FAIL single_pulse_width got=%b exp=0", e_write); end
        tx_busy = 1'b1;
        repeat (100) @(negedge clk);
        total++; if (arb_busy !== 1'b1)       begin bad++; $display("FAIL single_busy_mid got=%b exp=1", arb_busy); end
        total++; if (sent_cnt !== 16'd0)      begin bad++; $display("FAIL single_cnt_mid got=%0d exp=0", sent_cnt); end
        tx_busy = 1'b0;
        @(negedge clk);
        total++; if (sent_cnt !== 16'd1)      begin bad++; $display("FAIL single_sent_cnt got=%0d exp=1", sent_cnt); end
        total++; if (arb_busy !== 1'b0)       begin bad++; $display("FAIL single_arb_idle got=%b exp=0", arb_busy); end
    endtask

    task automatic test_simultaneous();
        int          exp_g [4] = '{0, 2, 0, 2};
        logic [31:0] exp_d [4] = '{32'h11, 32'h33, 32'h11, 32'h33};
        int          g;
        logic [31:0] wd;
        apply_reset();
        data = 32'h44332211;
        for (int k = 0; k < 4; k++) begin
            do_xfer(4'b0101, 1'b0, g, wd);
            total++; if (g !== exp_g[k])  begin bad++; $display("FAIL sim_grant[%0d] got=%0d exp=%0d", k, g, exp_g[k]); end
            total++; if (wd !== exp_d[k]) begin bad++; $display("FAIL sim_w_data[%0d] got=%h exp=%h", k, wd, exp_d[k]); end
        end
        req = '0;
    endtask

    task automatic test_back_to_back();
        int          g;
        logic [31:0] wd;
        apply_reset();
        data = 32'hD4C3B2A1;
        for (int k = 0; k < 8; k++) begin
            do_xfer(4'b1111, 1'b0, g, wd);
            total++; if (g !== (k % 4)) begin bad++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, g, k % 4); end
        end
        req = '0;
        total++; if (sent_cnt !== 16'd8) begin bad++; $display("FAIL rr_sent_cnt got=%0d exp=8", sent_cnt); end
    endtask

    task automatic test_timeout();
        int          g;
        logic [31:0] wd;
        bit          seen;
        apply_reset();
        data = 32'h44332211;
        req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (e_write === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL to_write got=none exp=write"); end
        req = '0;
        repeat (16) @(negedge clk);
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL to_err_early got=%b exp=0", err); end
        @(negedge clk);
        total++; if (err !== 1'b1)      begin bad++; $display("FAIL to_err got=%b exp=1", err); end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", arb_busy); end
        total++; if (sent_cnt !== 16'd0) begin bad++; $display("FAIL to_sent_cnt got=%0d exp=0", sent_cnt); end
        do_xfer(4'b0010, 1'b1, g, wd);
        total++; if (g !== 1)            begin bad++; $display("FAIL to_next_grant got=%0d exp=1", g); end
        total++; if (wd !== 32'h22)      begin bad++; $display("FAIL to_next_w_data got=%h exp=22", wd); end
        total++; if (sent_cnt !== 16'd1) begin bad++; $display("FAIL to_next_cnt got=%0d exp=1", sent_cnt); end
        total++; if (err !== 1'b1)       begin bad++; $display("FAIL to_err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid();
        int          g;
        logic [31:0] wd;
        bit          seen;
        req = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (e_write === 1'b1) seen = 1'b1;
        end
        req = '0;
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (arb_busy !== 1'b1) begin bad++; $display("FAIL rm_in_flight got=%b exp=1", arb_busy); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (arb_busy !== 1'b0)  begin bad++; $display("FAIL rm_arb_busy got=%b exp=0", arb_busy); end
        total++; if (err !== 1'b0)       begin bad++; $display("FAIL rm_err got=%b exp=0", err); end
        total++; if (sent_cnt !== 16'd0) begin bad++; $display("FAIL rm_sent_cnt got=%0d exp=0", sent_cnt); end
        total++; if (w_data !== 32'h0)   begin bad++; $display("FAIL rm_w_data got=%h exp=0", w_data); end
        total++; if (grant !== 4'b0 || e_write !== 1'b0) begin bad++; $display("FAIL rm_write got=%b/%b exp=0000/0", grant, e_write); end
        rst = 1'b0;
        tx_busy = 1'b0;
        do_xfer(4'b1111, 1'b1, g, wd);
        total++; if (g !== 0) begin bad++; $display("FAIL rm_first_grant got=%0d exp=0", g); end
        req = '0;
    endtask

    task automatic test_blocked();
        int writes;
        apply_reset();
        data = 32'h44332211;
        tx_busy = 1'b1;
        req = 4'b0010;
        writes = 0;
        repeat (6) begin
            @(negedge clk);
            if (e_write !== 1'b0) writes++;
        end
        total++; if (writes !== 0) begin bad++; $display("FAIL blk_no_write got=%0d exp=0", writes); end
        tx_busy = 1'b0;
        @(negedge clk);
        total++; if (e_write !== 1'b1)  begin bad++; $display("FAIL blk_write got=%b exp=1", e_write); end
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL blk_grant got=%b exp=0010", grant); end
        total++; if (w_data !== 32'h22) begin bad++; $display("FAIL blk_w_data got=%h exp=22", w_data); end
        req = '0;
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        total++; if (sent_cnt !== 16'd1) begin bad++; $display("FAIL blk_sent_cnt got=%0d exp=1", sent_cnt); end
    endtask

    initial begin
        rst = 1'b1; req = '0; data = '0; tx_busy = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_blocked();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
